// File: rtl/nios_system_pio_pkg.sv
// Shared constants for the Nios PIO family: register map, edge and IRQ mode encodings.
package nios_system_pio_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_RSVD    = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

    localparam int IRQ_NONE  = 0;
    localparam int IRQ_LEVEL = 1;
    localparam int IRQ_EDGE  = 2;

    // Debounce counter width; never zero so a bypassed instance still elaborates.
    function automatic int cnt_width(input int n);
        return (n > 0) ? $clog2(n + 1) : 1;
    endfunction

endpackage

// File: rtl/nios_system_pio_debounce.sv
// One input bit: SYNC_STAGES-flop synchroniser followed by an optional stable-count debouncer.
// Latency SYNC_STAGES edges to sync_out, plus DEBOUNCE_CYCLES edges to stable; no backpressure.
module nios_system_pio_debounce
    import nios_system_pio_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic stable
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_out;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
        assign stable = sync_out;
    end else begin : g_debounce
        localparam int CW = cnt_width(DEBOUNCE_CYCLES);
        localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

        logic [CW-1:0] cnt;
        logic          stable_q;

        // Any cycle where the input agrees with stable restarts the count, so glitches die here.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                cnt      <= '0;
                stable_q <= 1'b0;
            end else if (sync_out != stable_q) begin
                if (cnt == CNT_LAST) begin
                    stable_q <= sync_out;
                    cnt      <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end

        assign stable = stable_q;
    end

endmodule

// File: rtl/nios_system_pio_in_edge.sv
// Avalon-MM input PIO: synchronised/debounced inputs, W1C edge capture, maskable IRQ.
// Read latency 1 (readdata loaded every clock); input-to-capture SYNC_STAGES+1+DEBOUNCE_CYCLES edges; slave never stalls.
module nios_system_pio_in_edge
    import nios_system_pio_pkg::*;
#(
    parameter int DATA_WIDTH      = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0,
    parameter int EDGE_TYPE       = 0,
    parameter int IRQ_MODE        = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic [31:0]           readdata,
    output logic                  irq
);

    logic [DATA_WIDTH-1:0] stable;
    logic [DATA_WIDTH-1:0] prev;
    logic [DATA_WIDTH-1:0] edge_bit;
    logic [DATA_WIDTH-1:0] edgecapture;
    logic [DATA_WIDTH-1:0] irqmask;
    logic [DATA_WIDTH-1:0] clear;
    logic [31:0]           rd_mux;
    logic                  wr_en;
    logic                  unused_wdata;

    assign wr_en        = chipselect & ~write_n;
    assign unused_wdata = ^writedata;

    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_bit
        nios_system_pio_debounce #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk     (clk),
            .reset_n (reset_n),
            .din     (in_port[i]),
            .stable  (stable[i])
        );
    end

    always_comb begin
        edge_bit = stable ^ prev;
        if (EDGE_TYPE == EDGE_RISING) begin
            edge_bit = stable & ~prev;
        end else if (EDGE_TYPE == EDGE_FALLING) begin
            edge_bit = ~stable & prev;
        end
    end

    assign clear = (wr_en && address == ADDR_EDGECAP) ? writedata[DATA_WIDTH-1:0] : '0;

    // Edge term is OR-ed after the clear so a same-cycle edge survives the W1C write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev        <= '0;
            edgecapture <= '0;
        end else begin
            prev        <= stable;
            edgecapture <= (edgecapture & ~clear) | edge_bit;
        end
    end

    if (IRQ_MODE == IRQ_NONE) begin : g_no_mask
        assign irqmask = '0;
        assign irq     = 1'b0;
    end else begin : g_mask
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                irqmask <= '0;
            end else if (wr_en && address == ADDR_IRQMASK) begin
                irqmask <= writedata[DATA_WIDTH-1:0];
            end
        end

        if (IRQ_MODE == IRQ_LEVEL) begin : g_level
            assign irq = |(stable & irqmask);
        end else begin : g_edge
            assign irq = |(edgecapture & irqmask);
        end
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DATA:    rd_mux[DATA_WIDTH-1:0] = stable;
            ADDR_IRQMASK: rd_mux[DATA_WIDTH-1:0] = irqmask;
            ADDR_EDGECAP: rd_mux[DATA_WIDTH-1:0] = edgecapture;
            default:      rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_nios_system_pio_in_edge.sv
// Bench for nios_system_pio_in_edge: four parameterisations, directed sequences, W32 vector table, random run vs delay-line model.
module tb_nios_system_pio_in_edge;

    localparam int NR  = 400;
    localparam int OFF = 3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic        cs_def = 1'b0, cs_deb = 1'b0, cs_mode = 1'b0, cs_w32 = 1'b0;

    logic [7:0]  in_port_def = 8'h00, in_port_deb = 8'h00, in_port_mode = 8'h00;
    logic [31:0] in_port_w32 = '0;
    logic [31:0] readdata_def, readdata_deb, readdata_mode, readdata_w32;
    logic        irq_def, irq_deb, irq_mode, irq_w32;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    nios_system_pio_in_edge u_def (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs_def),
        .write_n(write_n), .writedata(writedata), .in_port(in_port_def),
        .readdata(readdata_def), .irq(irq_def)
    );

    nios_system_pio_in_edge #(.DEBOUNCE_CYCLES(4)) u_deb (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs_deb),
        .write_n(write_n), .writedata(writedata), .in_port(in_port_deb),
        .readdata(readdata_deb), .irq(irq_deb)
    );

    nios_system_pio_in_edge #(.EDGE_TYPE(1), .IRQ_MODE(1)) u_mode (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs_mode),
        .write_n(write_n), .writedata(writedata), .in_port(in_port_mode),
        .readdata(readdata_mode), .irq(irq_mode)
    );

    nios_system_pio_in_edge #(.DATA_WIDTH(32)) u_w32 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs_w32),
        .write_n(write_n), .writedata(writedata), .in_port(in_port_w32),
        .readdata(readdata_w32), .irq(irq_w32)
    );

    typedef struct {
        logic [1:0]  addr;
        logic        wr;
        logic [31:0] wd;
        logic [31:0] inp;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    vec_t vecs [10];

    logic [7:0] inp_h [0:NR+OFF];
    logic [7:0] ec_m, mask_m;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic bus_write(input int sel, input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        cs_def    = (sel == 0);
        cs_deb    = (sel == 1);
        cs_mode   = (sel == 2);
        cs_w32    = (sel == 3);
        address   = a;
        writedata = d;
        write_n   = 1'b0;
        @(negedge clk);
        cs_def = 1'b0; cs_deb = 1'b0; cs_mode = 1'b0; cs_w32 = 1'b0;
        write_n = 1'b1;
    endtask

    initial begin
        logic [2:0]  irq_hist;
        logic        seen;
        logic [10:0] rd_hist;
        logic        r_wr;
        logic [1:0]  r_addr;
        logic [31:0] r_wd;
        logic [7:0]  clr;
        logic [31:0] exp_rd;

        vecs[0] = '{2'd0, 1'b0, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
        vecs[1] = '{2'd0, 1'b1, 32'h12345678, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
        vecs[2] = '{2'd1, 1'b0, 32'h0,        32'hDEADBEEF, 32'h00000000, 1'b0};
        vecs[3] = '{2'd1, 1'b1, 32'hFFFFFFFF, 32'hDEADBEEF, 32'h00000000, 1'b0};
        vecs[4] = '{2'd3, 1'b0, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
        vecs[5] = '{2'd2, 1'b1, 32'h80000000, 32'hDEADBEEF, 32'h80000000, 1'b1};
        vecs[6] = '{2'd3, 1'b1, 32'hFFFFFFFF, 32'hDEADBEEF, 32'h00000000, 1'b0};
        vecs[7] = '{2'd3, 1'b0, 32'h0,        32'hFFFFFFFF, 32'h21524110, 1'b0};
        vecs[8] = '{2'd0, 1'b0, 32'h0,        32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0};
        vecs[9] = '{2'd2, 1'b1, 32'h00000010, 32'hFFFFFFFF, 32'h00000010, 1'b1};

        // Reset with inputs held high
        in_port_def = 8'hA5;
        in_port_w32 = 32'hDEADBEEF;
        repeat (3) @(negedge clk);
        check("reset_rd_def", readdata_def, 32'h0);
        check("reset_irq_def", {31'b0, irq_def}, 32'h0);
        check("reset_rd_w32", readdata_w32, 32'h0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_data_a5", readdata_def, 32'h000000A5);
        address = 2'd3;
        repeat (2) @(negedge clk);
        check("reset_edgecap_a5", readdata_def, 32'h000000A5);
        check("reset_irq_masked", {31'b0, irq_def}, 32'h0);

        // Edge and IRQ on bit 0
        in_port_def = 8'hA4;
        repeat (4) @(negedge clk);
        bus_write(0, 2'd2, 32'h01);
        bus_write(0, 2'd3, 32'hFF);
        check("edge_irq_idle", {31'b0, irq_def}, 32'h0);
        address = 2'd3;
        in_port_def = 8'hA5;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            irq_hist[k] = irq_def;
        end
        check("edge_irq_latency", {29'b0, irq_hist}, 32'h4);
        @(negedge clk);
        check("edge_cap_01", readdata_def, 32'h00000001);
        bus_write(0, 2'd3, 32'h01);
        check("edge_irq_clear", {31'b0, irq_def}, 32'h0);

        // Clear and new edge on bit 3 in the same cycle
        in_port_def = 8'hAD;
        @(negedge clk);
        @(negedge clk);
        cs_def = 1'b1; write_n = 1'b0; address = 2'd3; writedata = 32'h08;
        @(negedge clk);
        cs_def = 1'b0; write_n = 1'b1;
        @(negedge clk);
        check("simul_edge_wins", readdata_def, 32'h00000008);
        bus_write(0, 2'd3, 32'h08);
        @(negedge clk);
        check("plain_clear", readdata_def, 32'h00000000);

        // Debounce: 3-cycle glitch rejected
        address = 2'd0;
        in_port_deb = 8'h02;
        repeat (3) @(negedge clk);
        in_port_deb = 8'h00;
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (readdata_deb != 32'h0) seen = 1'b1;
        end
        check("deb_glitch_data", {31'b0, seen}, 32'h0);
        address = 2'd3;
        repeat (2) @(negedge clk);
        check("deb_glitch_edge", readdata_deb, 32'h0);

        // Debounce: 6-cycle pulse passes
        address = 2'd0;
        in_port_deb = 8'h02;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            rd_hist[k] = readdata_deb[1];
            if (k == 6) in_port_deb = 8'h00;
        end
        check("deb_pulse_pre", {31'b0, rd_hist[6]}, 32'h0);
        check("deb_pulse_on", {31'b0, rd_hist[7]}, 32'h1);
        address = 2'd3;
        repeat (8) @(negedge clk);
        check("deb_pulse_edge", readdata_deb, 32'h00000002);
        check("deb_irq_masked", {31'b0, irq_deb}, 32'h0);

        // Falling-edge capture with level IRQ
        bus_write(2, 2'd2, 32'h80);
        address = 2'd2;
        repeat (2) @(negedge clk);
        check("mode_mask_rd", readdata_mode, 32'h00000080);
        address = 2'd3;
        in_port_mode = 8'h80;
        @(negedge clk);
        check("mode_irq_e1", {31'b0, irq_mode}, 32'h0);
        @(negedge clk);
        check("mode_irq_high", {31'b0, irq_mode}, 32'h1);
        repeat (3) @(negedge clk);
        check("mode_no_rise_cap", readdata_mode, 32'h0);
        in_port_mode = 8'h00;
        @(negedge clk);
        check("mode_irq_hold", {31'b0, irq_mode}, 32'h1);
        @(negedge clk);
        check("mode_irq_low", {31'b0, irq_mode}, 32'h0);
        repeat (2) @(negedge clk);
        check("mode_fall_cap", readdata_mode, 32'h00000080);

        // 32-bit vector table
        for (int v = 0; v < 10; v++) begin
            in_port_w32 = vecs[v].inp;
            if (vecs[v].wr) bus_write(3, vecs[v].addr, vecs[v].wd);
            address = vecs[v].addr;
            repeat (5) @(negedge clk);
            check($sformatf("vec%0d_rd", v), readdata_w32, vecs[v].exp_rd);
            check($sformatf("vec%0d_irq", v), {31'b0, irq_w32}, {31'b0, vecs[v].exp_irq});
        end

        // Random run on the default instance against a delay-line model
        reset_n = 1'b0;
        in_port_def = 8'h00;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i <= NR + OFF; i++) inp_h[i] = 8'h00;
        ec_m = 8'h00;
        mask_m = 8'h00;
        for (int c = 1; c <= NR; c++) begin
            r_wr   = ($urandom_range(0, 3) == 0);
            r_addr = 2'($urandom_range(0, 3));
            r_wd   = $urandom;
            inp_h[c+OFF] = ($urandom_range(0, 2) == 0) ? 8'($urandom) : inp_h[c-1+OFF];
            in_port_def = inp_h[c+OFF];
            cs_def    = r_wr;
            write_n   = ~r_wr;
            address   = r_addr;
            writedata = r_wd;
            @(negedge clk);
            // data visible two edges late; a rise seen between c-3 and c-2 is captured at edge c
            case (r_addr)
                2'd0:    exp_rd = {24'b0, inp_h[c-2+OFF]};
                2'd2:    exp_rd = {24'b0, mask_m};
                2'd3:    exp_rd = {24'b0, ec_m};
                default: exp_rd = 32'h0;
            endcase
            clr  = (r_wr && r_addr == 2'd3) ? r_wd[7:0] : 8'h00;
            ec_m = (ec_m & ~clr) | (inp_h[c-2+OFF] & ~inp_h[c-3+OFF]);
            if (r_wr && r_addr == 2'd2) mask_m = r_wd[7:0];
            check("rand_rd", readdata_def, exp_rd);
            check("rand_irq", {31'b0, irq_def}, {31'b0, |(ec_m & mask_m)});
        end
        cs_def = 1'b0;
        write_n = 1'b1;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
